// File: rtl/regfile_param_if.sv
// regfile_param_if
//   Pipeline-side bundle for regfile_param: decode read ports, writeback
//   write port, clear request and the ready indication.
//
//   Parameters
//     XLEN   data width in bits
//     NREAD  number of read ports
//
//   Signals
//     clr     clear-sweep request (synchronous)
//     a_rs    read addresses, port k at [5k+4:5k]
//     d_rs    read data, port k at [XLEN*k+XLEN-1:XLEN*k]
//     a_rd    write address
//     d_rd    write data
//     we_rd   write enable
//     ready   register file initialised and accepting traffic
//
//   Modports
//     master  pipeline side (drives requests, observes data/ready)
//     slave   register file side
interface regfile_param_if #(
  parameter int XLEN  = 32,
  parameter int NREAD = 2
);
  logic                  clr;
  logic [5*NREAD-1:0]    a_rs;
  logic [XLEN*NREAD-1:0] d_rs;
  logic [4:0]            a_rd;
  logic [XLEN-1:0]       d_rd;
  logic                  we_rd;
  logic                  ready;

  modport master (
    output clr,
    output a_rs,
    output a_rd,
    output d_rd,
    output we_rd,
    input  d_rs,
    input  ready
  );

  modport slave (
    input  clr,
    input  a_rs,
    input  a_rd,
    input  d_rd,
    input  we_rd,
    output d_rs,
    output ready
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param
//   Parametrised RV32I/RV32E pipeline register file. Decode reads through
//   NREAD combinational ports, writeback writes through one synchronous port.
//   The storage array has no reset (it maps onto LUT/distributed RAM), so
//   after reset or a clr request a sweep writes zero to x1..x(NREGS-1), one
//   register per cycle. ready is high only once that sweep has finished.
//
//   Parameters
//     XLEN   data width (default 32)
//     NREGS  architectural register count, 16 (RV32E) or 32 (RV32I)
//     NREAD  read port count, 1..4
//
//   Ports
//     clk     clock, rising edge
//     resetb  asynchronous active-low reset (restarts the clear sweep)
//     bus     regfile_param_if.slave: clr, a_rs/d_rs, a_rd/d_rd/we_rd, ready
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, a write in flight is forwarded to any
//                        read port addressing the same register in the same
//                        cycle. When undefined, reads return the old value
//                        until the edge after the write.
module regfile_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic            clk,
  input  logic            resetb,
  regfile_param_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  generate
    if (NREGS != 16 && NREGS != 32) begin : g_bad_nregs
      $error("regfile_param: NREGS must be 16 or 32");
    end
    if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
      $error("regfile_param: NREAD must be in 1..4");
    end
  endgenerate

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [4:0] cnt;
  logic [4:0] cnt_nx;

  logic [XLEN-1:0] mem [NREGS];

  logic                  wr_ok;
  logic [XLEN*NREAD-1:0] d_rs_int;
  logic [4:0]            ra;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= CLEAR;
      cnt   <= 5'd1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic. x0 is never stored, so the sweep starts at 1 and
  // ends after writing NREGS-1.
  // ------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      CLEAR: begin
        if (bus.clr) begin
          cnt_nx = 5'd1;
        end else if (cnt == 5'(NREGS - 1)) begin
          state_nx = RUN;
          cnt_nx   = 5'd1;
        end else begin
          cnt_nx = cnt + 5'd1;
        end
      end
      RUN: begin
        if (bus.clr) begin
          state_nx = CLEAR;
          cnt_nx   = 5'd1;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = 5'd1;
      end
    endcase
  end

  assign bus.ready = (state == RUN);

  // ------------------------------------------------------------------
  // Write port. clr wins over a simultaneous write; writes to x0 or to
  // registers beyond NREGS are discarded.
  // ------------------------------------------------------------------
  assign wr_ok = (state == RUN) && !bus.clr && bus.we_rd &&
                 (bus.a_rd != 5'd0) &&
                 ({1'b0, bus.a_rd} < 6'(NREGS));

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt[AW-1:0]] <= '0;
    end else if (wr_ok) begin
      mem[bus.a_rd[AW-1:0]] <= bus.d_rd;
    end
  end

  // ------------------------------------------------------------------
  // Read ports. Everything reads zero until the sweep is done, so no
  // uninitialised storage can leak out. The bypass reuses wr_ok so a
  // forwarded value is always one that will actually be committed.
  // ------------------------------------------------------------------
  always_comb begin
    d_rs_int = '0;
    ra       = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra = bus.a_rs[5*k +: 5];
      if ((state == RUN) && (ra != 5'd0) && ({1'b0, ra} < 6'(NREGS))) begin
        d_rs_int[XLEN*k +: XLEN] = mem[ra[AW-1:0]];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (ra == bus.a_rd)) begin
          d_rs_int[XLEN*k +: XLEN] = bus.d_rd;
        end
`endif
      end
    end
  end

  assign bus.d_rs = d_rs_int;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//   Directed bench for regfile_param. Instance u_a: RV32I, 2 read ports.
//   Instance u_b: RV32E (16 registers), 4 read ports. Expected read data is
//   queued when a step is driven and compared shortly after the negedge.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic rstn_a;
  logic rstn_b;

  regfile_param_if #(.XLEN(32), .NREAD(2)) bus_a ();
  regfile_param_if #(.XLEN(32), .NREAD(4)) bus_b ();

  regfile_param #(.XLEN(32), .NREGS(32), .NREAD(2)) u_a (
    .clk    (clk_tb),
    .resetb (rstn_a),
    .bus    (bus_a.slave)
  );

  regfile_param #(.XLEN(32), .NREGS(16), .NREAD(4)) u_b (
    .clk    (clk_tb),
    .resetb (rstn_b),
    .bus    (bus_b.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    bit          sel;
    int unsigned port;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  logic [31:0] mdl [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rd_port(input bit sel, input int unsigned p);
    if (sel) return bus_b.d_rs[p*32 +: 32];
    else     return bus_a.d_rs[p*32 +: 32];
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.ready : bus_a.ready;
  endfunction

  task automatic expect_rd(input string tag, input bit sel, input int unsigned port,
                           input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.port = port;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, rd_port(e.sel, e.port), e.exp);
    end
  endtask

  task automatic drv_a(input bit clr, input bit we, input logic [4:0] rd,
                       input logic [31:0] d, input logic [4:0] rs0, input logic [4:0] rs1);
    bus_a.clr   = clr;
    bus_a.we_rd = we;
    bus_a.a_rd  = rd;
    bus_a.d_rd  = d;
    bus_a.a_rs  = {rs1, rs0};
  endtask

  task automatic drv_b(input bit we, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] r3);
    bus_b.clr   = 1'b0;
    bus_b.we_rd = we;
    bus_b.a_rd  = rd;
    bus_b.d_rd  = d;
    bus_b.a_rs  = {r3, r2, r1, r0};
  endtask

  // Counts negedges seen with ready low, starting with the current one.
  // On u_a it can inject a clr or a write to x2 at a given count.
  task automatic count_sweep(input bit sel, input int clr_at, input int wr_at, output int n);
    n = 0;
    for (int guard = 0; guard < 200; guard++) begin
      if (rdy(sel)) break;
      n++;
      if (!sel) begin
        if (n == clr_at)     drv_a(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        else if (n == wr_at) drv_a(1'b0, 1'b1, 5'd2, 32'h55, 5'd0, 5'd0);
        else                 drv_a(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      end
      @(negedge clk_tb);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0] wa, r0, r1;

    rstn_a = 1'b1;
    rstn_b = 1'b1;
    drv_a(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    drv_b(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    #1;
    chk("reset_ready_a", {31'b0, bus_a.ready}, 32'd0);
    chk("reset_ready_b", {31'b0, bus_b.ready}, 32'd0);
    repeat (3) @(negedge clk_tb);

    // Initial sweep on u_a
    rstn_a = 1'b1;
    count_sweep(1'b0, 0, 0, n);
    chk("sweep_len_a", 32'(n), 32'd31);

    // Preload x5, then reset asynchronously mid-cycle
    @(negedge clk_tb);
    drv_a(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    @(negedge clk_tb);
    drv_a(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    expect_rd("preload_x5_p0", 1'b0, 0, 32'hDEADBEEF);
    expect_rd("preload_x5_p1", 1'b0, 1, 32'hDEADBEEF);
    #1 drain();
    #2 rstn_a = 1'b0;
    #1;
    chk("async_reset_ready", {31'b0, bus_a.ready}, 32'd0);
    expect_rd("in_reset_x5_p0", 1'b0, 0, 32'd0);
    drain();
    @(negedge clk_tb);
    rstn_a = 1'b1;
    count_sweep(1'b0, 0, 0, n);
    chk("resweep_len_a", 32'(n), 32'd31);
    @(negedge clk_tb);
    drv_a(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    expect_rd("cleared_x5_p0", 1'b0, 0, 32'd0);
    expect_rd("cleared_x5_p1", 1'b0, 1, 32'd0);
    #1 drain();

    // Sequential write/read stream
    for (int k = 0; k < 32; k++) mdl[k] = 32'd0;
    for (int i = 0; i < 40; i++) begin
      wa = 5'(i % 32);
      r0 = 5'((i + 31) % 32);
      r1 = 5'((i + 30) % 32);
      @(negedge clk_tb);
      drv_a(1'b0, 1'b1, wa, 32'(32 - (i % 32)), r0, r1);
      expect_rd($sformatf("seq%0d_rs1", i), 1'b0, 0, mdl[r0]);
      expect_rd($sformatf("seq%0d_rs2", i), 1'b0, 1, mdl[r1]);
      #1 drain();
      if (wa != 5'd0) mdl[wa] = 32'(32 - (i % 32));
    end

    // Same-cycle write and read of x7 on both ports
    @(negedge clk_tb);
    drv_a(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    expect_rd("same_cycle_x7_p0", 1'b0, 0, BYP ? 32'h12345678 : mdl[7]);
    expect_rd("same_cycle_x7_p1", 1'b0, 1, BYP ? 32'h12345678 : mdl[7]);
    #1 drain();
    mdl[7] = 32'h12345678;
    @(negedge clk_tb);
    drv_a(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    expect_rd("next_cycle_x7_p0", 1'b0, 0, 32'h12345678);
    expect_rd("next_cycle_x7_p1", 1'b0, 1, 32'h12345678);
    #1 drain();

    // clr in RUN together with a write of x3
    @(negedge clk_tb);
    drv_a(1'b1, 1'b1, 5'd3, 32'd9, 5'd0, 5'd0);
    #1 chk("ready_before_clr", {31'b0, bus_a.ready}, 32'd1);
    @(negedge clk_tb);
    drv_a(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd3);
    #1;
    chk("ready_after_clr", {31'b0, bus_a.ready}, 32'd0);
    expect_rd("clear_read_x7", 1'b0, 0, 32'd0);
    drain();
    count_sweep(1'b0, 0, 0, n);
    chk("clr_sweep_len", 32'(n), 32'd31);
    @(negedge clk_tb);
    drv_a(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd7);
    expect_rd("x3_after_clr", 1'b0, 0, 32'd0);
    expect_rd("x7_after_clr", 1'b0, 1, 32'd0);
    #1 drain();

    // clr, restart at sweep cycle 10, write to x2 at sweep cycle 20
    @(negedge clk_tb);
    drv_a(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk_tb);
    count_sweep(1'b0, 10, 20, n);
    chk("restart_sweep_len", 32'(n), 32'd41);
    @(negedge clk_tb);
    drv_a(1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd2);
    expect_rd("x2_clear_write_p0", 1'b0, 0, 32'd0);
    expect_rd("x2_clear_write_p1", 1'b0, 1, 32'd0);
    #1 drain();

    // RV32E instance
    @(negedge clk_tb);
    rstn_b = 1'b1;
    count_sweep(1'b1, 0, 0, n);
    chk("sweep_len_b", 32'(n), 32'd15);
    @(negedge clk_tb);
    drv_b(1'b1, 5'd4, 32'hA5, 5'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk_tb);
    drv_b(1'b1, 5'd15, 32'h15, 5'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk_tb);
    drv_b(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int p = 0; p < 4; p++) expect_rd($sformatf("wr_x0_p%0d", p), 1'b1, p, 32'd0);
    #1 drain();
    @(negedge clk_tb);
    drv_b(1'b1, 5'd20, 32'hFFFFFFFF, 5'd20, 5'd20, 5'd20, 5'd20);
    for (int p = 0; p < 4; p++) expect_rd($sformatf("wr_x20_p%0d", p), 1'b1, p, 32'd0);
    #1 drain();
    @(negedge clk_tb);
    drv_b(1'b0, 5'd0, 32'd0, 5'd0, 5'd20, 5'd0, 5'd20);
    for (int p = 0; p < 4; p++) expect_rd($sformatf("rd_x0_x20_p%0d", p), 1'b1, p, 32'd0);
    #1 drain();
    @(negedge clk_tb);
    drv_b(1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 5'd4, 5'd4);
    for (int p = 0; p < 4; p++) expect_rd($sformatf("x4_p%0d", p), 1'b1, p, 32'hA5);
    #1 drain();
    @(negedge clk_tb);
    drv_b(1'b0, 5'd0, 32'd0, 5'd15, 5'd4, 5'd16, 5'd31);
    expect_rd("x15_p0", 1'b1, 0, 32'h15);
    expect_rd("x4_p1",  1'b1, 1, 32'hA5);
    expect_rd("x16_p2", 1'b1, 2, 32'd0);
    expect_rd("x31_p3", 1'b1, 3, 32'd0);
    #1 drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
